// File: rtl/dial_lock_pkg.sv
// Shared types and constants for the rotary-dial combination lock.
package dial_lock_pkg;

  typedef logic [3:0] digit_t;

  typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DOWN} dir_t;

  localparam int unsigned NUM_DIGITS     = 6;
  localparam int unsigned DIAL_POSITIONS = 10;

  // Distance from one dial position to another, walking upward around the dial.
  function automatic digit_t dial_delta(digit_t from, digit_t to);
    logic [4:0] d;
    d = {1'b0, to} + 5'(DIAL_POSITIONS) - {1'b0, from};
    if (d >= 5'(DIAL_POSITIONS)) d = d - 5'(DIAL_POSITIONS);
    return d[3:0];
  endfunction

endpackage

// File: rtl/onehot_to_digit.sv
// Decodes a 10-bit one-hot dial position; anything not exactly one-hot is invalid.
module onehot_to_digit
  import dial_lock_pkg::*;
(
  input  logic [9:0] onehot_i,
  output digit_t     digit_o,
  output logic       valid_o
);

  always_comb begin
    digit_o = '0;
    valid_o = 1'b1;
    unique case (onehot_i)
      10'b00_0000_0001: digit_o = 4'd0;
      10'b00_0000_0010: digit_o = 4'd1;
      10'b00_0000_0100: digit_o = 4'd2;
      10'b00_0000_1000: digit_o = 4'd3;
      10'b00_0001_0000: digit_o = 4'd4;
      10'b00_0010_0000: digit_o = 4'd5;
      10'b00_0100_0000: digit_o = 4'd6;
      10'b00_1000_0000: digit_o = 4'd7;
      10'b01_0000_0000: digit_o = 4'd8;
      10'b10_0000_0000: digit_o = 4'd9;
      default:          valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/dial_lock.sv
// Rotary-dial combination lock: each direction reversal latches a digit, tryopen evaluates.
// Optional consecutive-failure lockout is compiled in with DIAL_LOCK_LOCKOUT_EN.
module dial_lock
  import dial_lock_pkg::*;
#(
  parameter int unsigned MAX_FAILS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key0,
  input  logic [3:0] key1,
  input  logic [3:0] key2,
  input  logic [3:0] key3,
  input  logic [3:0] key4,
  input  logic [3:0] key5,
  input  logic [9:0] keypad,
  input  logic       tryopen,
  output logic       lockoutput
);

  localparam logic [2:0] LastIdx = 3'(NUM_DIGITS - 1);

  digit_t     kp_digit;
  logic       kp_valid;
  digit_t     pos_q;
  logic       pos_valid_q;
  dir_t       dir_q;
  logic [2:0] idx_q;
  logic       err_q;
  logic       tryopen_q;
  digit_t     digits_q [NUM_DIGITS-1];

  onehot_to_digit u_decode (
    .onehot_i (keypad),
    .digit_o  (kp_digit),
    .valid_o  (kp_valid)
  );

  digit_t delta;
  logic   step_up, step_dn, try_edge, open_ok;

  assign delta    = dial_delta(pos_q, kp_digit);
  assign step_up  = (delta == 4'd1);
  assign step_dn  = (delta == 4'd9);
  assign try_edge = tryopen && !tryopen_q;
  assign open_ok  = (idx_q == LastIdx) && (dir_q != DIR_NONE) && !err_q &&
                    (digits_q[0] == key0) && (digits_q[1] == key1) &&
                    (digits_q[2] == key2) && (digits_q[3] == key3) &&
                    (digits_q[4] == key4) && (pos_q == key5);

`ifdef DIAL_LOCK_LOCKOUT_EN
  localparam int unsigned CntW = (MAX_FAILS < 1) ? 1 : $clog2(MAX_FAILS + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_FAILS);
  logic [CntW-1:0] fail_cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      lockoutput  <= 1'b0;
      pos_q       <= '0;
      pos_valid_q <= 1'b0;
      dir_q       <= DIR_NONE;
      idx_q       <= '0;
      err_q       <= 1'b0;
      tryopen_q   <= 1'b0;
      for (int i = 0; i < NUM_DIGITS - 1; i++) digits_q[i] <= '0;
`ifdef DIAL_LOCK_LOCKOUT_EN
      fail_cnt_q  <= '0;
`endif
    end else begin
      tryopen_q <= tryopen;
      if (try_edge) begin
`ifdef DIAL_LOCK_LOCKOUT_EN
        if (fail_cnt_q >= MaxCnt) begin
          lockoutput <= 1'b0;
        end else if (open_ok) begin
          lockoutput <= 1'b1;
          fail_cnt_q <= '0;
        end else begin
          lockoutput <= 1'b0;
          fail_cnt_q <= fail_cnt_q + CntW'(1);
        end
`else
        lockoutput <= open_ok;
`endif
        dir_q <= DIR_NONE;
        idx_q <= '0;
        err_q <= 1'b0;
        // A coincident dial move only sets the start position of the next attempt.
        if (kp_valid) begin
          pos_q       <= kp_digit;
          pos_valid_q <= 1'b1;
        end
      end else if (kp_valid) begin
        if (!pos_valid_q) begin
          pos_q       <= kp_digit;
          pos_valid_q <= 1'b1;
        end else if (kp_digit != pos_q) begin
          pos_q <= kp_digit;
          if (step_up || step_dn) begin
            if (dir_q == DIR_NONE) begin
              if (step_up) dir_q <= DIR_UP;
              else         err_q <= 1'b1;
            end else if ((dir_q == DIR_UP) != step_up) begin
              dir_q <= step_up ? DIR_UP : DIR_DOWN;
              if (idx_q == LastIdx) begin
                err_q <= 1'b1;
              end else begin
                digits_q[idx_q] <= pos_q;
                idx_q           <= idx_q + 3'd1;
              end
            end
          end else begin
            err_q <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dial_lock.sv
// Directed bench for dial_lock: trajectory-based reference model plus literal checks.
module tb_dial_lock;

`ifdef DIAL_LOCK_LOCKOUT_EN
  localparam bit LOCKOUT = 1'b1;
`else
  localparam bit LOCKOUT = 1'b0;
`endif
  localparam int MAXF = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key0 = 4'd1, key1 = 4'd7, key2 = 4'd2, key3 = 4'd8, key4 = 4'd3, key5 = 4'd9;
  logic [9:0] keypad = '0;
  logic       tryopen = 1'b0;
  logic       lockoutput;

  int checks = 0;
  int errors = 0;

  dial_lock #(.MAX_FAILS(MAXF)) dut (
    .clk        (clk),
    .rst        (rst),
    .key0       (key0),
    .key1       (key1),
    .key2       (key2),
    .key3       (key3),
    .key4       (key4),
    .key5       (key5),
    .keypad     (keypad),
    .tryopen    (tryopen),
    .lockoutput (lockoutput)
  );

  always #5 clk = ~clk;

  // Model: record the dial trajectory of the current attempt and judge it at tryopen.
  int  path[$];
  int  m_pos = 0;
  bit  m_pv = 0;
  bit  m_prev_try = 0;
  bit  m_lock = 0;
  int  m_fails = 0;
  bit  cmp_en = 0;

  function automatic bit judge();
    int dig[$];
    int s, sprev, d, n;
    int keys[6];
    keys = '{int'(key0), int'(key1), int'(key2), int'(key3), int'(key4), int'(key5)};
    n = path.size();
    if (n < 2) return 1'b0;
    sprev = 0;
    for (int i = 1; i < n; i++) begin
      d = (path[i] - path[i-1] + 10) % 10;
      if (d == 1)      s = 1;
      else if (d == 9) s = -1;
      else             return 1'b0;
      if (sprev == 0) begin
        if (s < 0) return 1'b0;
      end else if (s != sprev) begin
        dig.push_back(path[i-1]);
      end
      sprev = s;
    end
    if (dig.size() != 5) return 1'b0;
    for (int i = 0; i < 5; i++) if (dig[i] != keys[i]) return 1'b0;
    return path[n-1] == keys[5];
  endfunction

  always @(posedge clk) begin
    bit kv;
    int kp;
    bit ok;
    kv = !$isunknown(keypad) && ($countones(keypad) == 1);
    kp = 0;
    for (int i = 0; i < 10; i++) if (kv && keypad[i]) kp = i;
    if (rst) begin
      m_lock = 0; m_pv = 0; m_pos = 0; m_prev_try = 0; m_fails = 0;
      path.delete();
    end else begin
      if (tryopen && !m_prev_try) begin
        ok = judge();
        if (LOCKOUT && m_fails >= MAXF) m_lock = 0;
        else if (ok) begin
          m_lock = 1; m_fails = 0;
        end else begin
          m_lock = 0;
          if (m_fails < MAXF) m_fails++;
        end
        if (kv) begin m_pos = kp; m_pv = 1; end
        path.delete();
        if (m_pv) path.push_back(m_pos);
      end else if (kv) begin
        if (!m_pv) begin
          m_pos = kp; m_pv = 1; path.delete(); path.push_back(kp);
        end else if (kp != m_pos) begin
          m_pos = kp; path.push_back(kp);
        end
      end
      m_prev_try = tryopen;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      checks++;
      if (lockoutput !== m_lock) begin
        errors++;
        $display("FAIL model t=%0t: lockoutput=%b expected=%b", $time, lockoutput, m_lock);
      end
    end
  end

  task automatic check(input string name, input logic exp);
    checks++;
    if (lockoutput !== exp) begin
      errors++;
      $display("FAIL %s: lockoutput=%b expected=%b", name, lockoutput, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Negative codes drive invalid dial values: -1 none, -2 two-hot, -3 unknown.
  task automatic set_pos(input int p);
    if (p >= 0) begin
      keypad = 10'd1 << p;
      repeat (5) step();
    end else begin
      if (p == -1)      keypad = 10'b0;
      else if (p == -2) keypad = 10'b00_0000_0011;
      else              keypad = 'x;
      repeat (2) step();
    end
  endtask

  int cur_path[$];

  // Clear with a tryopen pulse whose edge coincides with moving to the start, then dial.
  task automatic attempt(input int start, input bit exp, input string name);
    keypad  = 10'd1 << start;
    tryopen = 1'b1;
    repeat (2) step();
    tryopen = 1'b0;
    repeat (3) step();
    foreach (cur_path[i]) set_pos(cur_path[i]);
    tryopen = 1'b1;
    step();
    check({name, "_edge"}, exp);
    repeat (3) step();
    check({name, "_held"}, exp);
    tryopen = 1'b0;
    repeat (2) step();
  endtask

  int good[$];

  initial begin
    good = '{7, 8, 9, 0, 1, 0, 9, 8, 7, 8, 9, 0, 1, 2, 1, 0, 9, 8, 9, 0, 1, 2, 3, 2, 1, 0, 9};
    rst = 1'b1;
    repeat (3) step();
    cmp_en = 1'b1;
    check("reset", 1'b0);
    rst = 1'b0;
    step();
    check("after_reset", 1'b0);

    cur_path = good;
    attempt(7, 1'b1, "correct");

    cur_path = good;
    void'(cur_path.pop_back());
    attempt(7, 1'b0, "last_at_0");

    cur_path = good;
    cur_path[1] = 9;
    attempt(7, 1'b0, "skip_step");

    cur_path = '{1, 0, 9, 8, 9, 0, 1};
    attempt(1, 1'b0, "first_down");

    cur_path = good[0:22];
    attempt(7, 1'b0, "five_digits");

    cur_path = good;
    attempt(7, !LOCKOUT, "correct_again");

    cur_path = '{7, -1, 8, 9, -2, 0, 1, 0, -3, 9, 8, 7, 8, 9, 0, 1, 2, 1, 0, 9, 8,
                 9, 0, 1, 2, 3, 2, 1, 0, -1, 9};
    attempt(7, !LOCKOUT, "invalid_keys");

    // Reset in the middle of an entry, coincident with a tryopen edge.
    keypad = 10'd1 << 7;
    tryopen = 1'b1; repeat (2) step(); tryopen = 1'b0; repeat (2) step();
    for (int i = 0; i < 12; i++) set_pos(good[i]);
    rst = 1'b1; tryopen = 1'b1;
    step();
    check("reset_mid_entry", 1'b0);
    rst = 1'b0;
    step();
    tryopen = 1'b0;
    repeat (2) step();

    cur_path = good;
    attempt(7, 1'b1, "correct_after_reset");

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
